// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encodings,
// register-index width, the stage-control bundle and its NOP/idle value,
// plus small saturating-increment helpers.
// Optional feature macro used by the slice: HAZ_PERF_CNT_EN (performance counters).
package pipe_hazard_ctrl_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_ERR     = 2'd2
    } haz_state_e;

    // Per-cycle pipeline control bundle driven by the controller.
    typedef struct packed {
        logic hold_if;
        logic hold_id;
        logic hold_ix;
        logic hold_im;
        logic bubble_ix;
        logic bubble_iw;
        logic flush_id;
    } haz_ctrl_t;

    // NOP control value: every hold/bubble/flush inactive.
    localparam haz_ctrl_t NOP_CTRL          = haz_ctrl_t'(7'b0000000);
    // Whole pipeline frozen while data memory is outstanding.
    localparam haz_ctrl_t MEM_HOLD_CTRL     = haz_ctrl_t'(7'b1111010);
    // Taken branch: squash IF-ID, insert bubble into ID-IX.
    localparam haz_ctrl_t BRANCH_FLUSH_CTRL = haz_ctrl_t'(7'b0000101);
    // Load-use: freeze PC and IF-ID, insert bubble into ID-IX.
    localparam haz_ctrl_t LDU_STALL_CTRL    = haz_ctrl_t'(7'b1100100);

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            sat_inc8 = value;
        end else begin
            sat_inc8 = value + 8'd1;
        end
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        if (value == 32'hFFFF_FFFF) begin
            sat_inc32 = value;
        end else begin
            sat_inc32 = value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller interface. The master modport is the
// pipeline (reports stage contents, obeys controls); the slave modport is
// the controller. With HAZ_PERF_CNT_EN defined the performance counters
// are carried as extra controller outputs.
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    logic [REG_IDX_W-1:0] id_rs;
    logic [REG_IDX_W-1:0] id_rt;
    logic                 id_uses_rt;
    logic                 ix_is_load;
    logic [REG_IDX_W-1:0] ix_rt;
    logic                 ix_branch_taken;
    logic                 dmem_req;
    logic                 dmem_ack;

    logic                 hold_if;
    logic                 hold_id;
    logic                 hold_ix;
    logic                 hold_im;
    logic                 bubble_ix;
    logic                 bubble_iw;
    logic                 flush_id;
    logic                 mem_err;
    logic [1:0]           state_o;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0]          ldu_cnt;
    logic [31:0]          mem_stall_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, ix_is_load, ix_rt, ix_branch_taken,
               dmem_req, dmem_ack,
        input  hold_if, hold_id, hold_ix, hold_im, bubble_ix, bubble_iw,
               flush_id, mem_err, state_o, ldu_cnt, mem_stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ix_is_load, ix_rt, ix_branch_taken,
               dmem_req, dmem_ack,
        output hold_if, hold_id, hold_ix, hold_im, bubble_ix, bubble_iw,
               flush_id, mem_err, state_o, ldu_cnt, mem_stall_cnt
    );
`else
    modport master (
        output id_rs, id_rt, id_uses_rt, ix_is_load, ix_rt, ix_branch_taken,
               dmem_req, dmem_ack,
        input  hold_if, hold_id, hold_ix, hold_im, bubble_ix, bubble_iw,
               flush_id, mem_err, state_o
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ix_is_load, ix_rt, ix_branch_taken,
               dmem_req, dmem_ack,
        output hold_if, hold_id, hold_ix, hold_im, bubble_ix, bubble_iw,
               flush_id, mem_err, state_o
    );
`endif

endinterface

// File: rtl/pipe_hazard_ctrl_ldu_detect.sv
// Load-use hazard detector: flags when the load in IX writes a register the
// instruction in ID is about to read. r0 is hardwired zero and never hazards.
module pipe_ldu_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic                 ix_is_load,
    input  logic [REG_IDX_W-1:0] ix_rt,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_uses_rt,
    output logic                 load_use
);

    logic rs_hit_s;
    logic rt_hit_s;

    // Compare the load destination against both possible ID source operands.
    always_comb begin
        rs_hit_s = (ix_rt == id_rs);
        rt_hit_s = id_uses_rt && (ix_rt == id_rt);
        load_use = ix_is_load && (ix_rt != ZERO_REG) && (rs_hit_s || rt_hit_s);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// data-memory wait stalls with a timeout into a sticky error state.
// Stage controls are combinational from state and inputs so they act in
// the same cycle the hazard is seen.
// Optional feature: define HAZ_PERF_CNT_EN to add saturating 32-bit
// load-use and memory-stall cycle counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pipe_hazard_ctrl_if.slave        bus
);

    // Last counter value tolerated before the wait is declared hung.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    haz_state_e state_r;
    haz_state_e state_nxt_s;
    logic [7:0] wait_cnt_r;
    logic [7:0] wait_cnt_nxt_s;
    logic       pend_flush_r;
    logic       pend_flush_nxt_s;
    logic       mem_err_r;
    logic       mem_err_nxt_s;
    haz_ctrl_t  ctrl_s;
    logic       load_use_s;

    pipe_ldu_detect u_ldu_detect (
        .ix_is_load (bus.ix_is_load),
        .ix_rt      (bus.ix_rt),
        .id_rs      (bus.id_rs),
        .id_rt      (bus.id_rt),
        .id_uses_rt (bus.id_uses_rt),
        .load_use   (load_use_s)
    );

    // Next-state and stage-control decode; memory stall outranks branch, branch outranks load-use.
    always_comb begin
        ctrl_s           = NOP_CTRL;
        state_nxt_s      = state_r;
        wait_cnt_nxt_s   = wait_cnt_r;
        pend_flush_nxt_s = pend_flush_r;
        mem_err_nxt_s    = mem_err_r;

        case (state_r)
            ST_RUN: begin
                if (bus.dmem_req && !bus.dmem_ack) begin
                    // Stall entry: freeze everything, remember a branch seen now.
                    ctrl_s           = MEM_HOLD_CTRL;
                    state_nxt_s      = ST_MEMWAIT;
                    wait_cnt_nxt_s   = 8'd0;
                    pend_flush_nxt_s = bus.ix_branch_taken;
                end else if (bus.ix_branch_taken) begin
                    ctrl_s = BRANCH_FLUSH_CTRL;
                end else if (load_use_s) begin
                    ctrl_s = LDU_STALL_CTRL;
                end else begin
                    ctrl_s = NOP_CTRL;
                end
            end

            ST_MEMWAIT: begin
                if (bus.dmem_ack) begin
                    // Release: a branch resolved during the stall is applied now.
                    state_nxt_s      = ST_RUN;
                    pend_flush_nxt_s = 1'b0;
                    if (pend_flush_r || bus.ix_branch_taken) begin
                        ctrl_s = BRANCH_FLUSH_CTRL;
                    end else if (load_use_s) begin
                        ctrl_s = LDU_STALL_CTRL;
                    end else begin
                        ctrl_s = NOP_CTRL;
                    end
                end else begin
                    ctrl_s           = MEM_HOLD_CTRL;
                    pend_flush_nxt_s = pend_flush_r || bus.ix_branch_taken;
                    wait_cnt_nxt_s   = sat_inc8(wait_cnt_r);
                    if (wait_cnt_r >= TIMEOUT_LAST) begin
                        state_nxt_s   = ST_ERR;
                        mem_err_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_MEMWAIT;
                    end
                end
            end

            ST_ERR: begin
                // Hung memory: pipeline stays frozen until reset.
                ctrl_s        = MEM_HOLD_CTRL;
                mem_err_nxt_s = 1'b1;
            end

            default: begin
                // Unreachable encoding: fall back to a safe running state.
                ctrl_s           = NOP_CTRL;
                state_nxt_s      = ST_RUN;
                wait_cnt_nxt_s   = 8'd0;
                pend_flush_nxt_s = 1'b0;
            end
        endcase

        if (!rst_n) begin
            ctrl_s = NOP_CTRL;
        end else begin
            ctrl_s = ctrl_s;
        end
    end

    // FSM state, wait counter, pending flush and sticky error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_RUN;
            wait_cnt_r   <= 8'd0;
            pend_flush_r <= 1'b0;
            mem_err_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            wait_cnt_r   <= wait_cnt_nxt_s;
            pend_flush_r <= pend_flush_nxt_s;
            mem_err_r    <= mem_err_nxt_s;
        end
    end

    assign bus.hold_if   = ctrl_s.hold_if;
    assign bus.hold_id   = ctrl_s.hold_id;
    assign bus.hold_ix   = ctrl_s.hold_ix;
    assign bus.hold_im   = ctrl_s.hold_im;
    assign bus.bubble_ix = ctrl_s.bubble_ix;
    assign bus.bubble_iw = ctrl_s.bubble_iw;
    assign bus.flush_id  = ctrl_s.flush_id;
    assign bus.mem_err   = mem_err_r;
    assign bus.state_o   = state_r;

`ifdef HAZ_PERF_CNT_EN
    logic        ldu_stall_s;
    logic [31:0] ldu_cnt_r;
    logic [31:0] mem_stall_cnt_r;

    assign ldu_stall_s = (ctrl_s == LDU_STALL_CTRL);

    // Saturating counters of load-use stall cycles and memory wait/error cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ldu_cnt_r       <= 32'd0;
            mem_stall_cnt_r <= 32'd0;
        end else begin
            if (ldu_stall_s) begin
                ldu_cnt_r <= sat_inc32(ldu_cnt_r);
            end else begin
                ldu_cnt_r <= ldu_cnt_r;
            end
            if (state_r != ST_RUN) begin
                mem_stall_cnt_r <= sat_inc32(mem_stall_cnt_r);
            end else begin
                mem_stall_cnt_r <= mem_stall_cnt_r;
            end
        end
    end

    assign bus.ldu_cnt       = ldu_cnt_r;
    assign bus.mem_stall_cnt = mem_stall_cnt_r;
`endif

endmodule
